// File: rtl/joypad_serializer.sv
// joypad_serializer
// Controller port engine for NES/SNES-style pads. Each port latches a button
// image while the console strobe is high, then shifts out one bit per falling
// edge of that port's serial clock. A free-running splitter scheduler
// time-multiplexes one physical pad into ports 0 and 1. Per-button turbo gates
// masked buttons with a slow square wave. After a full read, the fill bit is
// returned on every further read until the next strobe.

module joypad_serializer #(
    parameter int NUM_PORTS = 2,
    parameter int BITS      = 8,
    parameter bit FILL_BIT  = 1'b0,
    parameter int SPLIT_DIV = 1024,
    parameter int SETTLE    = 16,
    parameter int TURBO_DIV = 500000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_PORTS*BITS-1:0] pad_in,
    input  logic [NUM_PORTS*BITS-1:0] turbo_mask,
    input  logic                      split_en,
    output logic                      split_sel,
    input  logic                      joy_strobe,
    input  logic [NUM_PORTS-1:0]      joy_clock,
    output logic [NUM_PORTS-1:0]      joy_data
);

    localparam int SC_W = $clog2(SPLIT_DIV);
    localparam int TC_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

    localparam logic [SC_W-1:0] SC_LAST   = SC_W'(SPLIT_DIV - 1);
    localparam logic [SC_W-1:0] SC_SETTLE = SC_W'(SETTLE);
    localparam logic [TC_W-1:0] TC_LAST   = TC_W'(TURBO_DIV - 1);

    logic [SC_W-1:0]      sc;
    logic [TC_W-1:0]      tc;
    logic                 turbo_phase;
    logic [BITS-1:0]      split_img [2];
    logic [BITS-1:0]      sh        [NUM_PORTS];
    logic [BITS-1:0]      img       [NUM_PORTS];
    logic [NUM_PORTS-1:0] prev_clk;
    logic [NUM_PORTS-1:0] clk_fall;
    logic                 capture_win;

    assign clk_fall = prev_clk & ~joy_clock;

    // The splitter output is sampled only on the last count of a phase. By
    // then the external mux has had at least SETTLE cycles to settle since
    // split_sel toggled.
    assign capture_win = (sc == SC_LAST) && (sc >= SC_SETTLE);

    // Register each port's serial clock so that a falling edge can be seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_clk <= '0;
        end else begin
            prev_clk <= joy_clock;
        end
    end

    // Splitter scheduler: toggle the select at the end of every phase, and
    // capture the physical pad into the image of the pad currently selected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sc           <= '0;
            split_sel    <= 1'b0;
            split_img[0] <= '0;
            split_img[1] <= '0;
        end else if (!split_en) begin
            sc           <= '0;
            split_sel    <= 1'b0;
            split_img[0] <= '0;
            split_img[1] <= '0;
        end else begin
            if (sc == SC_LAST) begin
                sc        <= '0;
                split_sel <= ~split_sel;
            end else begin
                sc <= sc + 1'b1;
            end
            if (capture_win) begin
                split_img[split_sel] <= pad_in[BITS-1:0];
            end
        end
    end

    // Free-running turbo divider. The strobe does not affect it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tc          <= '0;
            turbo_phase <= 1'b0;
        end else if (tc == TC_LAST) begin
            tc          <= '0;
            turbo_phase <= ~turbo_phase;
        end else begin
            tc <= tc + 1'b1;
        end
    end

    // Effective image per port: select the pad source, then suppress
    // auto-fired buttons during the low half of the turbo period.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (split_en && (p < 2)) begin
                img[p] = split_img[p[0]];
            end else begin
                img[p] = pad_in[p*BITS +: BITS];
            end
            img[p] = img[p] & ~(turbo_mask[p*BITS +: BITS] & {BITS{~turbo_phase}});
        end
    end

    // Per-port shift register. A held strobe keeps reloading the image and
    // takes priority over a coincident clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                sh[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (joy_strobe) begin
                    sh[p] <= img[p];
                end else if (clk_fall[p]) begin
                    sh[p] <= {FILL_BIT, sh[p][BITS-1:1]};
                end
            end
        end
    end

    // The serial bit each console port sees is the bottom of its shift register.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            joy_data[p] = sh[p][0];
        end
    end

endmodule

// File: tb/tb_joypad_serializer.sv
// Directed testbench for joypad_serializer. Instance a is an NES-style pair
// with a fast splitter and turbo. Instance b is a single SNES-style port with
// fill bit 1.

module tb_joypad_serializer;

    logic        clk = 1'b0;
    logic        reset;

    logic [15:0] pad_a;
    logic [15:0] mask_a;
    logic        split_en_a;
    logic        split_sel_a;
    logic        strobe_a;
    logic [1:0]  jclk_a;
    logic [1:0]  jdata_a;

    logic [15:0] pad_b;
    logic [15:0] mask_b;
    logic        split_en_b;
    logic        split_sel_b;
    logic        strobe_b;
    logic [0:0]  jclk_b;
    logic [0:0]  jdata_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    joypad_serializer #(
        .NUM_PORTS(2), .BITS(8), .FILL_BIT(1'b0),
        .SPLIT_DIV(8), .SETTLE(2), .TURBO_DIV(4)
    ) dut_a (
        .clk(clk), .reset(reset), .pad_in(pad_a), .turbo_mask(mask_a),
        .split_en(split_en_a), .split_sel(split_sel_a), .joy_strobe(strobe_a),
        .joy_clock(jclk_a), .joy_data(jdata_a)
    );

    joypad_serializer #(
        .NUM_PORTS(1), .BITS(16), .FILL_BIT(1'b1),
        .SPLIT_DIV(4), .SETTLE(1), .TURBO_DIV(4)
    ) dut_b (
        .clk(clk), .reset(reset), .pad_in(pad_b), .turbo_mask(mask_b),
        .split_en(split_en_b), .split_sel(split_sel_b), .joy_strobe(strobe_b),
        .joy_clock(jclk_b), .joy_data(jdata_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fall_a(input logic [1:0] ports);
        jclk_a = jclk_a | ports;
        tick();
        jclk_a = jclk_a & ~ports;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pad_a = 16'hFFFF; mask_a = '0; split_en_a = 1'b0; strobe_a = 1'b0; jclk_a = '0;
        pad_b = 16'hFFFF; mask_b = '0; split_en_b = 1'b0; strobe_b = 1'b0; jclk_b = '0;
        #12;
        vectors++;
        if (jdata_a !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_jdata_a got %b want 00", jdata_a);
        end
        vectors++;
        if (jdata_b !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_jdata_b got %b want 0", jdata_b);
        end
        vectors++;
        if (split_sel_a !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_split_sel got %b want 0", split_sel_a);
        end
        @(posedge clk);
        #3 reset = 1'b0;
        tick();
        vectors++;
        if (jdata_a !== 2'b00) begin
            miscompares++;
            $display("FAIL post_reset_jdata_a got %b want 00", jdata_a);
        end
    endtask

    task automatic test_basic_read();
        logic [7:0] exp0;
        logic       e;
        exp0 = 8'hA5;
        pad_a = {8'h3D, 8'hA5};
        strobe_a = 1'b1;
        tick();
        tick();
        strobe_a = 1'b0;
        tick();
        vectors++;
        if (jdata_a !== 2'b11) begin
            miscompares++;
            $display("FAIL basic_first_bits got %b want 11", jdata_a);
        end
        for (int i = 1; i <= 9; i++) begin
            fall_a(2'b01);
            e = (i < 8) ? exp0[i] : 1'b0;
            vectors++;
            if (jdata_a[0] !== e) begin
                miscompares++;
                $display("FAIL basic_read_bit%0d got %b want %b", i, jdata_a[0], e);
            end
        end
        vectors++;
        if (jdata_a[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_port1_untouched got %b want 1", jdata_a[1]);
        end
    endtask

    task automatic test_fill_snes();
        logic [15:0] pat;
        logic        e;
        pat = 16'h0001;
        pad_b = pat;
        strobe_b = 1'b1;
        tick();
        strobe_b = 1'b0;
        tick();
        vectors++;
        if (jdata_b[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL snes_bit0 got %b want 1", jdata_b[0]);
        end
        for (int i = 1; i <= 18; i++) begin
            jclk_b = 1'b1;
            tick();
            jclk_b = 1'b0;
            tick();
            e = (i < 16) ? pat[i] : 1'b1;
            vectors++;
            if (jdata_b[0] !== e) begin
                miscompares++;
                $display("FAIL snes_read_%0d got %b want %b", i, jdata_b[0], e);
            end
        end
    endtask

    task automatic test_strobe_priority();
        pad_a = {8'h00, 8'h02};
        strobe_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fall_a(2'b01);
            vectors++;
            if (jdata_a[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL strobe_held_%0d got %b want 0", i, jdata_a[0]);
            end
        end
        // sh holds 8'h02; a shift would expose 1, a load of 8'h04 exposes 0
        strobe_a = 1'b0;
        pad_a = {8'h00, 8'h04};
        jclk_a[0] = 1'b1;
        tick();
        strobe_a = 1'b1;
        jclk_a[0] = 1'b0;
        tick();
        vectors++;
        if (jdata_a[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL strobe_edge_same_cycle got %b want 0", jdata_a[0]);
        end
        strobe_a = 1'b0;
        tick();
        fall_a(2'b01);
        fall_a(2'b01);
        vectors++;
        if (jdata_a[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL strobe_then_shift got %b want 1", jdata_a[0]);
        end
    endtask

    task automatic test_splitter();
        logic [7:0] b0;
        logic [7:0] b1;
        pad_a = {8'h99, 8'h11};
        split_en_a = 1'b1;
        strobe_a = 1'b1;
        tick();
        strobe_a = 1'b0;
        vectors++;
        if (jdata_a !== 2'b00) begin
            miscompares++;
            $display("FAIL split_pre_capture got %b want 00", jdata_a);
        end
        for (int n = 1; n <= 16; n++) begin
            if (n > 1) tick();
            vectors++;
            if (split_sel_a !== ((n >= 8 && n < 16) ? 1'b1 : 1'b0)) begin
                miscompares++;
                $display("FAIL split_sel_cycle%0d got %b want %b", n, split_sel_a,
                         (n >= 8 && n < 16) ? 1'b1 : 1'b0);
            end
            if (n == 8) pad_a[7:0] = 8'h22;
        end
        strobe_a = 1'b1;
        tick();
        strobe_a = 1'b0;
        b0 = '0;
        b1 = '0;
        for (int i = 0; i < 8; i++) begin
            b0[i] = jdata_a[0];
            b1[i] = jdata_a[1];
            fall_a(2'b11);
        end
        vectors++;
        if (b0 !== 8'h11) begin
            miscompares++;
            $display("FAIL split_port0_image got %h want 11", b0);
        end
        vectors++;
        if (b1 !== 8'h22) begin
            miscompares++;
            $display("FAIL split_port1_image got %h want 22", b1);
        end
        for (int k = 0; k < 20 && split_sel_a !== 1'b1; k++) tick();
        vectors++;
        if (split_sel_a !== 1'b1) begin
            miscompares++;
            $display("FAIL split_wait_sel_high got %b want 1", split_sel_a);
        end
        split_en_a = 1'b0;
        tick();
        vectors++;
        if (split_sel_a !== 1'b0) begin
            miscompares++;
            $display("FAIL split_disable_sel got %b want 0", split_sel_a);
        end
        pad_a = {8'h00, 8'h01};
        strobe_a = 1'b1;
        tick();
        strobe_a = 1'b0;
        vectors++;
        if (jdata_a !== 2'b01) begin
            miscompares++;
            $display("FAIL split_off_direct_pad got %b want 01", jdata_a);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] b0;
        pad_a = {8'h00, 8'hF8};
        strobe_a = 1'b1;
        tick();
        strobe_a = 1'b0;
        fall_a(2'b01);
        fall_a(2'b01);
        fall_a(2'b01);
        vectors++;
        if (jdata_a[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pre_bit3 got %b want 1", jdata_a[0]);
        end
        reset = 1'b1;
        #2;
        vectors++;
        if (jdata_a !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_mid_read got %b want 00", jdata_a);
        end
        #1 reset = 1'b0;
        split_en_a = 1'b1;
        for (int k = 0; k < 20 && split_sel_a !== 1'b1; k++) tick();
        reset = 1'b1;
        #2;
        vectors++;
        if (split_sel_a !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_split_sel_async got %b want 0", split_sel_a);
        end
        #1 reset = 1'b0;
        split_en_a = 1'b0;
        pad_a = {8'h00, 8'hFF};
        tick();
        strobe_a = 1'b1;
        tick();
        strobe_a = 1'b0;
        b0 = '0;
        for (int i = 0; i < 8; i++) begin
            b0[i] = jdata_a[0];
            fall_a(2'b01);
        end
        vectors++;
        if (b0 !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_reread got %h want ff", b0);
        end
    endtask

    task automatic test_turbo();
        logic e;
        mask_a = {8'h00, 8'h01};
        pad_a = {8'h01, 8'h03};
        split_en_a = 1'b0;
        strobe_a = 1'b1;
        tick();
        reset = 1'b1;
        #2 reset = 1'b0;
        // after edge n the shift register holds the image of turbo phase ((n-1)/4)&1
        for (int n = 1; n <= 14; n++) begin
            tick();
            if (n == 2 || n == 6 || n == 10 || n == 14) begin
                e = ((n - 1) / 4) % 2 == 1;
                vectors++;
                if (jdata_a !== {1'b1, e}) begin
                    miscompares++;
                    $display("FAIL turbo_edge%0d got %b want %b", n, jdata_a, {1'b1, e});
                end
            end
        end
        strobe_a = 1'b0;
        fall_a(2'b01);
        vectors++;
        if (jdata_a[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL turbo_unmasked_bit1 got %b want 1", jdata_a[0]);
        end
        mask_a = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_read();
        test_fill_snes();
        test_strobe_priority();
        test_splitter();
        test_async_reset();
        test_turbo();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
